// File: rtl/fp_acc_seq_if.sv
// fp_acc_seq_if: input stream, result stream and accumulator hookup for fp_acc_seq.
interface fp_acc_seq_if #(
  parameter int CNT_W = 8
);
  logic             in_valid_i, in_ready_o, in_last_i;
  logic [31:0]      in_data_i;
  logic             out_valid_o, out_ready_i, out_err_o;
  logic [31:0]      out_data_o;
  logic [CNT_W-1:0] out_count_o;
  logic             acc_en_o;
  logic [31:0]      acc_summand_o, acc_sum_i;
  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i, acc_sum_i,
    output in_ready_o, out_valid_o, out_data_o, out_count_o, out_err_o, acc_en_o, acc_summand_o
  );
  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i, acc_sum_i,
    input  in_ready_o, out_valid_o, out_data_o, out_count_o, out_err_o, acc_en_o, acc_summand_o
  );
endinterface

// File: rtl/fp_acc_seq.sv
// fp_acc_seq: FIFO-buffered sequencer feeding an FP32 running-sum accumulator, one result per vector.
module fp_acc_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input logic         clk_i,
  input logic         rst_n_i,
  fp_acc_seq_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_ACCUM, S_WAIT, S_CLEAR} state_t;
  state_t           r_state, w_next;
  logic [32:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt, r_out_count;
  logic [31:0]      r_out_data, w_summand;
  logic [32:0]      w_head;
  logic             r_out_valid, r_err, w_full, w_empty, w_push, w_pop, w_load, w_en;
  assign w_full  = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wptr == r_rptr;
  assign w_push  = bus.in_valid_i && !w_full;
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_en      = 1'b0;
    w_summand = '0;
    case (r_state)
      S_ACCUM: if (!w_empty) begin
        w_pop     = 1'b1;
        w_en      = 1'b1;
        w_summand = w_head[31:0];
        w_next    = w_head[32] ? S_WAIT : S_ACCUM;
      end
      S_WAIT: if (!r_out_valid || bus.out_ready_i) begin
        w_load = 1'b1;
        w_next = S_CLEAR;
      end
      S_CLEAR: begin
        // adding the negated sum yields +0 under round-to-nearest-even
        w_en      = 1'b1;
        w_summand = {~bus.acc_sum_i[31], bus.acc_sum_i[30:0]};
        w_next    = S_ACCUM;
      end
      default: w_next = S_ACCUM;
    endcase
  end
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {bus.in_last_i, bus.in_data_i};
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state     <= S_ACCUM;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (w_pop) r_cnt <= &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
      else if (w_load) r_cnt <= '0;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.acc_sum_i;
        r_out_count <= r_cnt;
      end else if (bus.out_ready_i) r_out_valid <= 1'b0;
      // an Inf/NaN accumulator cannot be cleared, so the flag is sticky
      if (r_state == S_CLEAR && &bus.acc_sum_i[30:23]) r_err <= 1'b1;
    end
  assign bus.in_ready_o    = !w_full;
  assign bus.out_valid_o   = r_out_valid;
  assign bus.out_data_o    = r_out_data;
  assign bus.out_count_o   = r_out_count;
  assign bus.out_err_o     = r_err;
  assign bus.acc_en_o      = w_en;
  assign bus.acc_summand_o = w_summand;
endmodule

// File: tb/tb_fp_acc_seq.sv
// tb_fp_acc_seq: directed vectors against a per-vector sum model, with an FP32 accumulator model attached.
module tb_fp_acc_seq;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;
  fp_acc_seq_if #(.CNT_W(CW)) bus();
  fp_acc_seq #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));
  typedef struct { logic [31:0] d; int c; int e; } res_t;
  res_t        q[$];
  int          n_tests = 0, n_fail = 0, rx_n = 0, v_n = 0;
  real         v_sum = 0.0;
  bit          poison = 0, saw_block = 0;
  logic [31:0] rx_d [32];
  int          rx_c [32];
  logic [31:0] acc = 32'h0;
  logic [31:0] pins [16] = '{32'h40C00000, 32'h40C00000, 32'h3F000000, 32'h00000000,
                             32'h40000000, 32'h40A00000, 32'h40400000, 32'h40800000,
                             32'h40E00000, 32'h3F800000, 32'h40000000, 32'h3F000000,
                             32'h40400000, 32'h7F800000, 32'h7FC00000, 32'h3F800000};
  function automatic bit is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'h0;
  endfunction
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'h0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'h0};
    else d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return d[51:0] != 52'h0 ? 32'h7FC00000 : {d[63], 8'hFF, 23'h0};
    if (e == 0) return {d[63], 31'h0};
    return {d[63], 8'(e - 896), d[51:29]};
  endfunction
  // accumulator stand-in: registered FP32 running sum, exact for the values used here
  assign bus.acc_sum_i = acc;
  always @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) acc <= 32'h0;
    else if (bus.acc_en_o) acc <= r2f(f2r(acc) + f2r(bus.acc_summand_o));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic chk_f(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (is_nan(exp) ? !is_nan(act) : act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  initial begin
    logic hold = 1'b0;
    logic [31:0] hold_d = 32'h0;
    logic [CW-1:0] hold_c = '0;
    res_t r;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) hold = 1'b0;
      else begin
        if (!bus.in_ready_o) saw_block = 1;
        if (!bus.acc_en_o) chk("summand_idle", bus.acc_summand_o, 32'h0);
        if (hold) begin
          chk("hold_valid", 32'(bus.out_valid_o), 32'h1);
          chk("hold_data", bus.out_data_o, hold_d);
          chk("hold_count", 32'(bus.out_count_o), 32'(hold_c));
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %h, want none", bus.out_data_o);
          end else begin
            r = q.pop_front();
            chk_f("result_data", bus.out_data_o, r.d);
            chk("result_count", 32'(bus.out_count_o), 32'(r.c));
            if (r.e != 2) chk("result_err", 32'(bus.out_err_o), 32'(r.e));
            if (rx_n < 32) begin
              rx_d[rx_n] = bus.out_data_o;
              rx_c[rx_n] = int'(bus.out_count_o);
            end
            rx_n++;
          end
        end
        hold   = bus.out_valid_o && !bus.out_ready_i;
        hold_d = bus.out_data_o;
        hold_c = bus.out_count_o;
      end
    end
  end
  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    res_t r;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.in_last_i  = l;
    while (!bus.in_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.in_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready 0, want 1");
    end
    @(posedge clk_i);
    #1 bus.in_valid_i = 1'b0;
    v_sum += f2r(d);
    v_n++;
    if (l) begin
      r.d = poison ? 32'h7FC00000 : r2f(v_sum);
      r.c = v_n > CMAX ? CMAX : v_n;
      r.e = poison ? 1 : (r.d[30:23] == 8'hFF ? 2 : 0);
      q.push_back(r);
      if (r.d[30:23] == 8'hFF) poison = 1;
      v_sum = 0.0;
      v_n   = 0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    rst_n_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    q.delete();
    v_sum  = 0.0;
    v_n    = 0;
    poison = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 32'h0;
    bus.in_last_i   = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
    chk("rst_out_data", bus.out_data_o, 32'h0);
    chk("rst_out_count", 32'(bus.out_count_o), 32'h0);
    chk("rst_out_err", 32'(bus.out_err_o), 32'h0);
    chk("rst_acc_en", 32'(bus.acc_en_o), 32'h0);
    rst_n_i = 1'b1;
    push(32'h3F800000, 0); push(32'h40000000, 0); push(32'h40400000, 1);
    drain();
    push(32'h3F800000, 0); push(32'h40000000, 0); push(32'h40400000, 1);
    push(32'h3F000000, 1);
    drain();
    push(32'h3F800000, 0); push(32'hBF800000, 1);
    push(32'h40000000, 1);
    drain();
    for (int i = 0; i < 5; i++) push(32'h3F800000, i == 4);
    drain();
    bus.out_ready_i = 1'b0;
    fork
      begin
        push(32'h40400000, 1); push(32'h40800000, 1); push(32'h40E00000, 1);
        push(32'h3F800000, 1); push(32'h40000000, 1); push(32'h3F000000, 1);
        push(32'h40400000, 1);
      end
      begin
        repeat (20) @(posedge clk_i);
        #1 bus.out_ready_i = 1'b1;
      end
    join
    drain();
    chk("backpressure_block", 32'(saw_block), 32'h1);
    push(32'h7F800000, 1);
    drain();
    chk("err_after_inf", 32'(bus.out_err_o), 32'h1);
    push(32'h3F800000, 1);
    drain();
    chk("err_sticky", 32'(bus.out_err_o), 32'h1);
    push(32'h40400000, 0);
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();
    chk("reset_err", 32'(bus.out_err_o), 32'h0);
    chk("reset_valid", 32'(bus.out_valid_o), 32'h0);
    push(32'h3F800000, 1);
    drain();
    chk("rx_total", 32'(rx_n), 32'd16);
    for (int i = 0; i < 16; i++) chk_f($sformatf("pin_data_%0d", i), rx_d[i], pins[i]);
    chk("pin_count_0", 32'(rx_c[0]), 32'd3);
    chk("pin_count_2", 32'(rx_c[2]), 32'd1);
    chk("pin_count_sat", 32'(rx_c[5]), 32'd3);
    chk("pin_count_15", 32'(rx_c[15]), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
